mem_store_ctrl: RTL and testbench
=================================

// Module: mem_store_ctrl
// PURPOSE
//   Write-side controller for the byte-wide external memory bus. Takes one store request
//   (address, 32-bit data, size) from the MEM stage and serialises it into 1, 2 or 4
//   consecutive single-byte write cycles, little-endian, then pulses done.
//   Pairs with the instruction-fetch read controller on the same addr/mem_ctrl_wr bus.
//   Bus arbitration between the two is outside this block.
// PARAMETERS
//   ADDR_W   32   width of st_addr and addr
//   DATA_W   32   width of st_data; fixed at 4 bytes, other values unsupported
// PORTS
//   clk          in   1       single clock, all logic on posedge
//   rst          in   1       synchronous reset, ACTIVE-LOW (rst==0 at posedge resets)
//   st_req       in   1       store request, sampled only in IDLE
//   st_addr      in   ADDR_W  byte address of least-significant byte
//   st_data      in   DATA_W  store data, byte 0 = st_data[7:0]
//   st_size      in   2       00 byte, 01 half, 10 word, 11 illegal
//   st_busy      out  1       1 while a request is held (WRITE and DONE states)
//   st_done      out  1       1-cycle pulse: store finished (or rejected)
//   st_err       out  1       1-cycle pulse with st_done when st_size==11
//   mem_ctrl_wr  out  1       1 = memory write cycle this clock
//   addr         out  ADDR_W  memory byte address
//   wdata        out  8       memory write byte
// BEHAVIOUR
//   Reset (rst==0): state=IDLE; st_busy, st_done, st_err, mem_ctrl_wr=0; addr=0; wdata=0.
//     Reset mid-operation aborts immediately: no further write cycles, no st_done.
//   States: IDLE, WRITE, DONE.
//   IDLE: mem_ctrl_wr=0, addr=0, wdata=0.
//     - st_req=1 and st_size!=11: latch st_addr/st_data, load cnt=1/2/4, go WRITE.
//     - st_req=1 and st_size==11: no latch, no write; next cycle st_done=1, st_err=1,
//       then IDLE. st_busy stays 0.
//   WRITE: one byte per cycle. Byte i (i=0..cnt-1) occupies the i-th cycle after accept:
//     mem_ctrl_wr=1, addr=A+i (mod 2^ADDR_W, so 0xFFFFFFFF wraps to 0x00000000),
//     wdata=D[8i+7:8i]. After the last byte -> DONE.
//   DONE: one cycle; mem_ctrl_wr=0, addr=0, st_done=1, st_busy=1; next state IDLE.
//   Latency: accept at cycle 0; write cycles 1..cnt; st_done at cycle cnt+1.
//     Earliest next accept is cycle cnt+2 (word: 6 cycles per store).
//   st_req while st_busy=1 (WRITE or DONE): ignored. Held inputs are not re-sampled.
//     Requester holds st_req until st_done or drops it; a request still asserted
//     when back in IDLE is treated as a new store.
//   Inputs may change after accept without effect on the store in progress.
//   Outputs are all registered; no combinational path input->output.
// TESTING
//   1. Word: A=0x100, D=0xDEADBEEF, size=10 -> cycles 1-4 write EF,BE,AD,DE
//      at 0x100-0x103; st_done at cycle 5; no other mem_ctrl_wr cycles.
//   2. Byte/half: A=0x20,D=0x1234ABCD,size=00 -> one write CD@0x20, done cycle 2;
//      size=01 -> CD@0x20, AB@0x21, done cycle 3.
//   3. Wrap: A=0xFFFFFFFE, D=0x11223344, size=10 -> 44@FFFFFFFE, 33@FFFFFFFF,
//      22@00000000, 11@00000001.
//   4. Reset mid-op: word store, drive rst=0 during cycle 2 -> next cycle all outputs 0,
//      only bytes already written remain, st_done never pulses.
//   5. Busy collision: second st_req with new addr/data during WRITE -> ignored; the
//      first store's bytes are unchanged, exactly one st_done.
//   6. Illegal: size=11 -> st_done=st_err=1 at cycle 1, mem_ctrl_wr never asserted.

Source files
------------

// File: rtl/mem_store_ctrl.sv
// mem_store_ctrl
//   Write-side controller for the byte-wide external memory bus. Accepts one store
//   (address, 32-bit data, size) and serialises it into 1, 2 or 4 consecutive
//   single-byte write cycles, least-significant byte first, then pulses st_done.
//   An illegal size (2'b11) is rejected with a st_done/st_err pulse and no write.
//
// Ports
//   clk          single clock, all logic on posedge
//   rst          synchronous reset, active low
//   st_req       store request, sampled only while idle
//   st_addr      byte address of the least-significant byte
//   st_data      store data, byte 0 = st_data[7:0]
//   st_size      00 byte, 01 half, 10 word, 11 illegal
//   st_busy      high while a store is held (write and done phases)
//   st_done      one-cycle pulse: store finished or rejected
//   st_err       one-cycle pulse alongside st_done for an illegal size
//   mem_ctrl_wr  memory write cycle this clock
//   addr         memory byte address
//   wdata        memory write byte
//
// All outputs are registered; there is no combinational input-to-output path.

module mem_store_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [1:0]        st_size,
  output logic              st_busy,
  output logic              st_done,
  output logic              st_err,
  output logic              mem_ctrl_wr,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        wdata
);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e            state_q;
  logic [1:0]        cnt_q;   // bytes still to go after the one currently on the bus
  logic [DATA_W-1:0] data_q;  // not-yet-written bytes, next one in [7:0]
  logic              st_busy_q;
  logic              st_done_q;
  logic              st_err_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      data_q    <= '0;
      st_busy_q <= 1'b0;
      st_done_q <= 1'b0;
      st_err_q  <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          st_busy_q <= 1'b0;
          st_done_q <= 1'b0;
          st_err_q  <= 1'b0;
          wr_q      <= 1'b0;
          addr_q    <= '0;
          wdata_q   <= '0;
          if (st_req) begin
            if (st_size == 2'b11) begin
              // Reject without leaving idle: the pulse shows next cycle, busy stays low.
              st_done_q <= 1'b1;
              st_err_q  <= 1'b1;
            end else begin
              // Byte 0 goes straight onto the bus so it appears in the first cycle.
              state_q   <= StWrite;
              st_busy_q <= 1'b1;
              wr_q      <= 1'b1;
              addr_q    <= st_addr;
              wdata_q   <= st_data[7:0];
              data_q    <= st_data >> 8;
              unique case (st_size)
                2'b00:   cnt_q <= 2'd0;
                2'b01:   cnt_q <= 2'd1;
                default: cnt_q <= 2'd3;
              endcase
            end
          end
        end

        StWrite: begin
          if (cnt_q == 2'd0) begin
            state_q   <= StDone;
            st_done_q <= 1'b1;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
          end else begin
            cnt_q   <= cnt_q - 2'd1;
            addr_q  <= addr_q + ADDR_W'(1);  // wraps modulo 2^ADDR_W
            wdata_q <= data_q[7:0];
            data_q  <= data_q >> 8;
          end
        end

        StDone: begin
          state_q   <= StIdle;
          st_busy_q <= 1'b0;
          st_done_q <= 1'b0;
        end

        default: begin
          state_q   <= StIdle;
          st_busy_q <= 1'b0;
          st_done_q <= 1'b0;
          st_err_q  <= 1'b0;
          wr_q      <= 1'b0;
          addr_q    <= '0;
          wdata_q   <= '0;
        end
      endcase
    end
  end

  assign st_busy     = st_busy_q;
  assign st_done     = st_done_q;
  assign st_err      = st_err_q;
  assign mem_ctrl_wr = wr_q;
  assign addr        = addr_q;
  assign wdata       = wdata_q;

endmodule

// File: tb/tb_mem_store_ctrl.sv
// Directed bench for mem_store_ctrl: word/byte/half stores, address wrap,
// reset mid-store, request collision while busy, illegal size.

module tb_mem_store_ctrl;

  logic        clk;
  logic        rst;
  logic        st_req;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_busy;
  logic        st_done;
  logic        st_err;
  logic        mem_ctrl_wr;
  logic [31:0] addr;
  logic [7:0]  wdata;

  int total;
  int bad;

  mem_store_ctrl #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .st_req     (st_req),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_size    (st_size),
    .st_busy    (st_busy),
    .st_done    (st_done),
    .st_err     (st_err),
    .mem_ctrl_wr(mem_ctrl_wr),
    .addr       (addr),
    .wdata      (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Compare every output against one expected cycle.
  task automatic expect_cycle(input string tag, input logic wr, input logic [31:0] a,
                              input logic [7:0] d, input logic busy, input logic done,
                              input logic err);
    chk({tag, ".wr"},    {63'd0, mem_ctrl_wr}, {63'd0, wr});
    chk({tag, ".addr"},  {32'd0, addr},        {32'd0, a});
    chk({tag, ".wdata"}, {56'd0, wdata},       {56'd0, d});
    chk({tag, ".busy"},  {63'd0, st_busy},     {63'd0, busy});
    chk({tag, ".done"},  {63'd0, st_done},     {63'd0, done});
    chk({tag, ".err"},   {63'd0, st_err},      {63'd0, err});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request now; the next edge accepts it and returns at cycle 1.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    st_req  = 1'b1;
    st_addr = a;
    st_data = d;
    st_size = sz;
    step();
    st_req  = 1'b0;
    st_addr = 32'hA5A5_A5A5;
    st_data = 32'h5A5A_5A5A;
    st_size = 2'b00;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b0;
    st_req  = 1'b0;
    st_addr = '0;
    st_data = '0;
    st_size = '0;
    step();
    step();
    expect_cycle("reset", 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    expect_cycle("idle0", 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Word store
    issue(32'h0000_0100, 32'hDEAD_BEEF, 2'b10);
    expect_cycle("w.b0", 1'b1, 32'h0000_0100, 8'hEF, 1'b1, 1'b0, 1'b0);
    step();
    expect_cycle("w.b1", 1'b1, 32'h0000_0101, 8'hBE, 1'b1, 1'b0, 1'b0);
    step();
    expect_cycle("w.b2", 1'b1, 32'h0000_0102, 8'hAD, 1'b1, 1'b0, 1'b0);
    step();
    expect_cycle("w.b3", 1'b1, 32'h0000_0103, 8'hDE, 1'b1, 1'b0, 1'b0);
    step();
    expect_cycle("w.done", 1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0);
    step();
    expect_cycle("w.idle", 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Byte store
    issue(32'h0000_0020, 32'h1234_ABCD, 2'b00);
    expect_cycle("b.b0", 1'b1, 32'h0000_0020, 8'hCD, 1'b1, 1'b0, 1'b0);
    step();
    expect_cycle("b.done", 1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0);
    step();
    expect_cycle("b.idle", 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Half store
    issue(32'h0000_0020, 32'h1234_ABCD, 2'b01);
    expect_cycle("h.b0", 1'b1, 32'h0000_0020, 8'hCD, 1'b1, 1'b0, 1'b0);
    step();
    expect_cycle("h.b1", 1'b1, 32'h0000_0021, 8'hAB, 1'b1, 1'b0, 1'b0);
    step();
    expect_cycle("h.done", 1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0);
    step();
    expect_cycle("h.idle", 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Address wrap
    issue(32'hFFFF_FFFE, 32'h1122_3344, 2'b10);
    expect_cycle("wr.b0", 1'b1, 32'hFFFF_FFFE, 8'h44, 1'b1, 1'b0, 1'b0);
    step();
    expect_cycle("wr.b1", 1'b1, 32'hFFFF_FFFF, 8'h33, 1'b1, 1'b0, 1'b0);
    step();
    expect_cycle("wr.b2", 1'b1, 32'h0000_0000, 8'h22, 1'b1, 1'b0, 1'b0);
    step();
    expect_cycle("wr.b3", 1'b1, 32'h0000_0001, 8'h11, 1'b1, 1'b0, 1'b0);
    step();
    expect_cycle("wr.done", 1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0);
    step();

    // Reset asserted during cycle 2 of a word store
    issue(32'h0000_0300, 32'hCAFE_F00D, 2'b10);
    expect_cycle("rm.b0", 1'b1, 32'h0000_0300, 8'h0D, 1'b1, 1'b0, 1'b0);
    step();
    expect_cycle("rm.b1", 1'b1, 32'h0000_0301, 8'hF0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    expect_cycle("rm.rst", 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_cycle("rm.after", 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    end

    // Second request while busy is ignored
    issue(32'h0000_0040, 32'h0102_0304, 2'b10);
    st_req  = 1'b1;
    st_addr = 32'h0000_0080;
    st_data = 32'hFFFF_FFFF;
    st_size = 2'b00;
    expect_cycle("c.b0", 1'b1, 32'h0000_0040, 8'h04, 1'b1, 1'b0, 1'b0);
    step();
    expect_cycle("c.b1", 1'b1, 32'h0000_0041, 8'h03, 1'b1, 1'b0, 1'b0);
    step();
    expect_cycle("c.b2", 1'b1, 32'h0000_0042, 8'h02, 1'b1, 1'b0, 1'b0);
    st_req = 1'b0;
    step();
    expect_cycle("c.b3", 1'b1, 32'h0000_0043, 8'h01, 1'b1, 1'b0, 1'b0);
    step();
    expect_cycle("c.done", 1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0);
    step();
    expect_cycle("c.idle0", 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    expect_cycle("c.idle1", 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Illegal size
    issue(32'h0000_0055, 32'h8765_4321, 2'b11);
    expect_cycle("ill.done", 1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 1'b1);
    step();
    expect_cycle("ill.idle0", 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    expect_cycle("ill.idle1", 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
